// File: rtl/qlearn_tables.sv
// qlearn_tables: Q/Qmax dual-port tables with post-reset clear sweep and computed reward; define QLEARN_TABLES_BYPASS_EN for write-first reads
module qlearn_tables #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 2**ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] q_addr_r,
  input  logic [ADDR_WIDTH-1:0] q_addr_w,
  input  logic                  q_write_en,
  input  logic [DATA_WIDTH-1:0] q_data,
  output logic [DATA_WIDTH-1:0] q_data_out,
  input  logic [ADDR_WIDTH-1:0] qmax_addr_r,
  input  logic [ADDR_WIDTH-1:0] qmax_addr_w,
  input  logic                  qmax_write_en,
  input  logic [DATA_WIDTH-1:0] qmax_data,
  output logic [DATA_WIDTH-1:0] qmax_data_out,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic                  r_read,
  output logic [DATA_WIDTH-1:0] r_data_out,
  output logic                  o_init_busy
);
  localparam int IW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] q_mem [DEPTH];
  logic [DATA_WIDTH-1:0] qmax_mem [DEPTH];
  logic [IW-1:0] init_addr, q_ra, q_wa, qm_ra, qm_wa;
  logic [DATA_WIDTH-1:0] q_wd, qm_wd, q_rd, qm_rd, reward;
  logic q_we, qm_we;
  logic [5:0] s;
  logic [1:0] a;
  logic [2:0] row, col, nrow, ncol;

  // the init sweep owns both write ports while busy, so user writes are dropped
  assign q_ra  = q_addr_r[IW-1:0];
  assign qm_ra = qmax_addr_r[IW-1:0];
  assign q_we  = o_init_busy | q_write_en;
  assign qm_we = o_init_busy | qmax_write_en;
  assign q_wa  = o_init_busy ? init_addr : q_addr_w[IW-1:0];
  assign qm_wa = o_init_busy ? init_addr : qmax_addr_w[IW-1:0];
  assign q_wd  = o_init_busy ? '0 : q_data;
  assign qm_wd = o_init_busy ? '0 : qmax_data;
`ifdef QLEARN_TABLES_BYPASS_EN
  assign q_rd  = (q_write_en && q_addr_w[IW-1:0] == q_ra) ? q_data : q_mem[q_ra];
  assign qm_rd = (qmax_write_en && qmax_addr_w[IW-1:0] == qm_ra) ? qmax_data : qmax_mem[qm_ra];
`else
  assign q_rd  = q_mem[q_ra];
  assign qm_rd = qmax_mem[qm_ra];
`endif

  // reward: move on the 8x8 grid, walls keep the state, entering the goal from elsewhere pays
  assign s    = r_addr[7:2];
  assign a    = r_addr[1:0];
  assign row  = s[5:3];
  assign col  = s[2:0];
  assign ncol = (a == 2'b00 && col != 3'd0) ? col - 3'd1 : (a == 2'b10 && col != 3'd7) ? col + 3'd1 : col;
  assign nrow = (a == 2'b01 && row != 3'd0) ? row - 3'd1 : (a == 2'b11 && row != 3'd7) ? row + 3'd1 : row;
  assign reward = ({nrow, ncol} == 6'h3f && s != 6'h3f) ? DATA_WIDTH'(8'h80) : '0;

  // clear sweep: one address per cycle, busy drops after the last address is written
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_init_busy <= 1'b1;
      init_addr   <= '0;
    end else if (o_init_busy) begin
      init_addr   <= init_addr + 1'b1;
      o_init_busy <= init_addr != IW'(DEPTH - 1);
    end

  // table storage, no reset so it maps onto block RAM
  always_ff @(posedge i_clk) begin
    if (q_we) q_mem[q_wa] <= q_wd;
    if (qm_we) qmax_mem[qm_wa] <= qm_wd;
  end

  // registered read ports, forced to zero while the tables are being cleared
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      q_data_out    <= '0;
      qmax_data_out <= '0;
      r_data_out    <= '0;
    end else begin
      q_data_out    <= o_init_busy ? '0 : q_rd;
      qmax_data_out <= o_init_busy ? '0 : qm_rd;
      if (r_read) r_data_out <= reward;
    end
endmodule

// File: tb/tb_qlearn_tables.sv
// tb_qlearn_tables: self-checking bench for qlearn_tables (reset sweep, tables, reward)
module tb_qlearn_tables;
`ifdef QLEARN_TABLES_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic i_clk = 0, i_rst_n = 0;
  logic [7:0] q_addr_r = 0, q_addr_w = 0, q_data = 0, q_data_out;
  logic [7:0] qmax_addr_r = 0, qmax_addr_w = 0, qmax_data = 0, qmax_data_out;
  logic q_write_en = 0, qmax_write_en = 0, r_read = 0, o_init_busy;
  logic [7:0] r_addr = 0, r_data_out;
  int checks = 0, errors = 0;
  logic [7:0] mq [256];
  logic [7:0] mm [256];
  logic [7:0] exp_r = 0;

  typedef struct { logic [7:0] addr; logic [7:0] exp; } rvec_t;
  rvec_t rv [8];

  qlearn_tables dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .q_addr_r(q_addr_r), .q_addr_w(q_addr_w), .q_write_en(q_write_en), .q_data(q_data), .q_data_out(q_data_out),
    .qmax_addr_r(qmax_addr_r), .qmax_addr_w(qmax_addr_w), .qmax_write_en(qmax_write_en), .qmax_data(qmax_data),
    .qmax_data_out(qmax_data_out),
    .r_addr(r_addr), .r_read(r_read), .r_data_out(r_data_out), .o_init_busy(o_init_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_reward(input int addr);
    int st, act, r, c, nr, nc;
    st = (addr >> 2) & 63;
    act = addr & 3;
    r = st / 8;
    c = st % 8;
    nr = r;
    nc = c;
    if (act == 0) nc = c - 1;
    if (act == 1) nr = r - 1;
    if (act == 2) nc = c + 1;
    if (act == 3) nr = r + 1;
    if (nr < 0 || nr > 7 || nc < 0 || nc > 7) begin
      nr = r;
      nc = c;
    end
    return (nr * 8 + nc == 63 && st != 63) ? 8'h80 : 8'h00;
  endfunction

  task automatic step(input string tag);
    logic [7:0] eq, em, er;
    eq = (BYP && q_write_en && q_addr_w == q_addr_r) ? q_data : mq[q_addr_r];
    em = (BYP && qmax_write_en && qmax_addr_w == qmax_addr_r) ? qmax_data : mm[qmax_addr_r];
    er = r_read ? ref_reward(int'(r_addr)) : exp_r;
    @(posedge i_clk);
    #1;
    if (q_write_en) mq[q_addr_w] = q_data;
    if (qmax_write_en) mm[qmax_addr_w] = qmax_data;
    exp_r = er;
    check({tag, "_q"}, q_data_out, eq);
    check({tag, "_qmax"}, qmax_data_out, em);
    check({tag, "_r"}, r_data_out, er);
  endtask

  task automatic sweep(output int n);
    n = 0;
    while (o_init_busy && n < 1000) begin
      if (n == 5) begin
        q_write_en = 1; q_addr_w = 8'h07; q_data = 8'hFF; q_addr_r = 8'h07;
        qmax_write_en = 1; qmax_addr_w = 8'h07; qmax_data = 8'hFF; qmax_addr_r = 8'h07;
      end
      if (n == 6) begin
        q_write_en = 0;
        qmax_write_en = 0;
      end
      @(posedge i_clk);
      #1;
      n++;
      if (n == 1) check("init_reward", r_data_out, 8'h80);
      if (n > 5 && n < 10) begin
        check("init_q_zero", q_data_out, 8'h00);
        check("init_qmax_zero", qmax_data_out, 8'h00);
      end
    end
    for (int i = 0; i < 256; i++) begin
      mq[i] = 0;
      mm[i] = 0;
    end
    exp_r = r_read ? ref_reward(int'(r_addr)) : exp_r;
  endtask

  initial begin
    int n;
    rv[0] = '{8'hFA, 8'h80}; rv[1] = '{8'hDF, 8'h80}; rv[2] = '{8'hFE, 8'h00}; rv[3] = '{8'h00, 8'h00};
    rv[4] = '{8'hFF, 8'h00}; rv[5] = '{8'hFB, 8'h00}; rv[6] = '{8'hBF, 8'h00}; rv[7] = '{8'hF6, 8'h00};
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_busy", o_init_busy, 1);
    check("rst_q", q_data_out, 0);
    check("rst_qmax", qmax_data_out, 0);
    check("rst_r", r_data_out, 0);
    r_read = 1;
    r_addr = 8'hFA;
    i_rst_n = 1;
    sweep(n);
    check("sweep_len", n, 256);
    check("busy_low", o_init_busy, 0);
    q_addr_r = 8'hA5; qmax_addr_r = 8'hA5;
    step("post_a5");
    check("a5_q", q_data_out, 0);
    check("a5_qmax", qmax_data_out, 0);
    q_addr_r = 8'h07; qmax_addr_r = 8'h07;
    step("post_07");
    check("init_write_ignored", q_data_out, 0);
    check("init_write_ignored_m", qmax_data_out, 0);
    repeat (100) @(posedge i_clk);
    #1;
    i_rst_n = 0;
    #1;
    check("mid_rst_r", r_data_out, 0);
    check("mid_rst_busy", o_init_busy, 1);
    #2;
    i_rst_n = 1;
    repeat (100) @(posedge i_clk);
    #1;
    check("sweep100_busy", o_init_busy, 1);
    i_rst_n = 0;
    #2;
    check("restart_busy", o_init_busy, 1);
    i_rst_n = 1;
    sweep(n);
    check("restart_len", n, 256);
    q_write_en = 1; q_addr_w = 8'h12; q_data = 8'h3C;
    step("w12");
    q_write_en = 0; q_addr_r = 8'h12; qmax_addr_r = 8'h12;
    step("r12");
    check("q12", q_data_out, 8'h3C);
    check("qmax12", qmax_data_out, 8'h00);
    qmax_write_en = 1; qmax_addr_w = 8'h40; qmax_data = 8'h11;
    step("w40_old");
    qmax_data = 8'h55; qmax_addr_r = 8'h40;
    step("rdw40");
    check("rdw_qmax", qmax_data_out, BYP ? 8'h55 : 8'h11);
    qmax_write_en = 0;
    step("r40");
    check("qmax40_new", qmax_data_out, 8'h55);
    r_read = 1;
    for (int i = 0; i < 8; i++) begin
      r_addr = rv[i].addr;
      step("rvec");
      check("reward_vec", r_data_out, rv[i].exp);
    end
    r_addr = 8'hDF;
    step("rset");
    r_read = 0;
    for (int i = 0; i < 3; i++) begin
      r_addr = 8'(i * 4);
      step("rhold");
      check("reward_hold", r_data_out, 8'h80);
    end
    for (int i = 0; i < 400; i++) begin
      q_write_en = 1'($urandom_range(0, 1)); qmax_write_en = 1'($urandom_range(0, 1));
      q_addr_w = 8'($urandom_range(0, 15)); q_addr_r = 8'($urandom_range(0, 15));
      qmax_addr_w = 8'($urandom_range(0, 15)); qmax_addr_r = 8'($urandom_range(0, 15));
      q_data = 8'($urandom); qmax_data = 8'($urandom);
      r_read = 1'($urandom_range(0, 1)); r_addr = 8'($urandom);
      step("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qlearn_tables.md
QLEARN_TABLES -- requirements
Module: qlearn_tables

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, table address width; address = {state[5:0], action[1:0]}.
REQ-002 Parameter DATA_WIDTH, default 8, table entry width (unsigned Q4.4).
REQ-003 Parameter DEPTH, default 2**ADDR_WIDTH (256), entries per table.
REQ-004 i_clk  in  1  single clock; all state changes on rising edge; one clock, reset asynchronous and active-low.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 q_addr_r / q_addr_w  in  ADDR_WIDTH  Q-table read / write address.
REQ-007 q_write_en  in  1  Q-table write strobe; q_data  in  DATA_WIDTH  write data; q_data_out  out  DATA_WIDTH  read data.
REQ-008 qmax_addr_r / qmax_addr_w / qmax_write_en / qmax_data / qmax_data_out: same meanings, widths and directions for the Qmax table.
REQ-009 r_addr  in  ADDR_WIDTH  reward address; r_read  in  1  reward read enable; r_data_out  out  DATA_WIDTH  reward.
REQ-010 o_init_busy  out  1  high while post-reset table clear runs.

Function
REQ-011 Q and Qmax tables SHALL each be DEPTH x DATA_WIDTH simple dual-port RAM: one synchronous write port, one synchronous read port.
REQ-012 Write: on rising edge with write_en=1 and o_init_busy=0, mem[addr_w] <= data.
REQ-013 Read: q_data_out/qmax_data_out SHALL register mem[addr_r] every edge; latency exactly 1 cycle; no read enable.
REQ-014 Read-during-write, same address, same edge: output SHALL be old contents (read-first) unless REQ-028 applies.
REQ-015 Writes to different addresses of the same table never interfere; Q and Qmax tables fully independent.
REQ-016 Reward table SHALL be read-only, computed from address: state s=r_addr[7:2], action a=r_addr[1:0]; grid row=s[5:3], col=s[2:0]; a: 00 left (col-1), 01 up (row-1), 10 right (col+1), 11 down (row+1).
REQ-017 Move into a wall (col=0&left, row=0&up, col=7&right, row=7&down) SHALL leave state unchanged.
REQ-018 Reward SHALL be 8'h80 when next state is 6'b111111 and s != 6'b111111; otherwise 8'h00 (including s=63 itself).
REQ-019 r_data_out SHALL update with computed reward on rising edge when r_read=1; hold previous value when r_read=0; latency 1 cycle.
REQ-020 Address bits above DEPTH range (if ADDR_WIDTH > log2 DEPTH) SHALL be ignored (wrap modulo DEPTH).

Reset
REQ-021 Asserting i_rst_n=0 SHALL immediately clear q_data_out, qmax_data_out, r_data_out to 0 and set o_init_busy=1.
REQ-022 After release, init sweep SHALL write 0 to both tables at addresses 0..DEPTH-1, one address per cycle, DEPTH cycles total; o_init_busy drops on the cycle after address DEPTH-1 is written.
REQ-023 During init, user writes SHALL be ignored and q/qmax read outputs SHALL read 0; reward table functions normally.
REQ-024 Reset asserted mid-sweep SHALL restart sweep from address 0 on release.

Configuration
REQ-025 Macro QLEARN_TABLES_BYPASS_EN selects read-during-write behaviour.
REQ-026 Without macro: read-first per REQ-014.
REQ-027 Macro affects Q and Qmax tables only; reward table unaffected.
REQ-028 With macro defined: same-address read and write on the same edge SHALL output the new write data (write-first); different addresses unaffected.

Verification
REQ-029 Reset pulse, release, count cycles -> o_init_busy high exactly 256 cycles; then read addr 8'hA5 on both tables -> 0 one cycle later.
REQ-030 Write Q[8'h12]=8'h3C, next cycle read 8'h12 -> q_data_out=8'h3C after 1 cycle; qmax_data_out for 8'h12 stays 0.
REQ-031 Same-edge write Qmax[8'h40]=8'h55 (old 8'h11) and read 8'h40 -> 8'h11 without macro, 8'h55 with QLEARN_TABLES_BYPASS_EN.
REQ-032 r_read=1, r_addr={6'd62,2'b10} -> 8'h80; {6'd55,2'b11} -> 8'h80; {6'd63,2'b10} -> 0; {6'd0,2'b00} -> 0.
REQ-033 r_read=0 while r_addr changes -> r_data_out holds last value.
REQ-034 Write during o_init_busy to 8'h07 = 8'hFF, then read after init -> 0; reset at sweep cycle 100 -> sweep restarts, busy 256 more cycles.
